play_frame_tx: RTL

// - Next-gen play analyser: captures one play (button + board position), builds the ASCII frame
//   "<btn>$<pos_tens><pos_units>#", registers a compare against an expected frame, and transmits
//   the frame over an integrated 7E1 UART. Own sequencing FSM; one request in, one pronto out.
// - Sits between the game UC/FD and the serial debug/host link.

---
 rtl/play_frame_tx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/play_frame_tx.sv
// play_frame_tx: captures a play, builds "<btn>$<tens><units>#", compares it with esperado and sends it over a 7E1 UART.
// Define FRAME_CRLF_EN to append CR/LF to the transmitted frame.
module play_frame_tx #(
  parameter int N_BOTOES = 4,
  parameter int POS_BITS = 2,
  parameter int BAUD_DIV = 434
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                registrar,
  input  logic [4:0]          especiais,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [POS_BITS-1:0] pos,
  input  logic                cancela,
  input  logic [34:0]         esperado,
  output logic                serial,
  output logic                ocupado,
  output logic                pronto,
  output logic                descartada,
  output logic                acertou,
  output logic [34:0]         resposta
);
  localparam int BW = $clog2(BAUD_DIV);
`ifdef FRAME_CRLF_EN
  localparam int FC = 7;
`else
  localparam int FC = 5;
`endif
  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_COMPARE, S_LOAD, S_SEND, S_NEXT, S_DONE} state_t;
  state_t          r_st, w_nxt;
  logic [BW-1:0]   r_baud;
  logic [3:0]      r_bit;
  logic [2:0]      r_chr;
  logic [8:0]      r_sh;
  logic            r_serial, r_cpend, r_pronto, r_desc, r_acert;
  logic [34:0]     r_resp;
  logic [6:0]      w_bot, w_btn, w_p, w_tens, w_units, w_char;
  logic [34:0]     w_frame;
  logic [7*FC-1:0] w_tx;
  logic            w_tick, w_cancel, w_fire, w_run;
  always_comb begin
    w_bot = 7'h3F;
    for (int i = N_BOTOES - 1; i >= 0; i--)
      if (botoes[i]) w_bot = 7'h41 + 7'(i);
  end
  assign w_btn = especiais[0] ? 7'h4A :
                 especiais[1] ? 7'h5A :
                 especiais[2] ? 7'h59 :
                 especiais[3] ? 7'h52 :
                 especiais[4] ? 7'h4C : w_bot;
  assign w_p     = 7'(pos);
  assign w_tens  = w_p / 7'd10;
  assign w_units = w_p % 7'd10;
  assign w_frame = {w_btn, 7'h24, 7'h30 + w_tens, 7'h30 + w_units, 7'h23};
`ifdef FRAME_CRLF_EN
  assign w_tx = {r_resp, 7'h0D, 7'h0A};
`else
  assign w_tx = r_resp;
`endif
  assign w_char   = w_tx[7*(FC-1-int'(r_chr)) +: 7];
  assign w_tick   = r_baud == BW'(BAUD_DIV - 1);
  assign w_cancel = r_cpend | cancela;
  // The first character loads at once; later ones wait for the previous stop bit to end.
  assign w_fire   = (r_st == S_LOAD) && (r_chr == 3'd0 || w_tick);
  assign w_run    = r_st inside {S_LOAD, S_SEND, S_NEXT, S_DONE};
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_st <= S_IDLE;
    else          r_st <= w_nxt;
  always_comb begin
    w_nxt = r_st;
    case (r_st)
      S_IDLE:    w_nxt = registrar ? S_CAPTURE : S_IDLE;
      S_CAPTURE: w_nxt = S_COMPARE;
      S_COMPARE: w_nxt = S_LOAD;
      S_LOAD:    w_nxt = w_fire ? (w_cancel ? S_IDLE : S_SEND) : S_LOAD;
      S_SEND:    w_nxt = (w_tick && r_bit == 4'd8) ? S_NEXT : S_SEND;
      S_NEXT:    w_nxt = (r_chr == 3'(FC)) ? S_DONE : S_LOAD;
      S_DONE:    w_nxt = w_tick ? S_IDLE : S_DONE;
      default:   w_nxt = S_IDLE;
    endcase
  end
  // Stop bit is held across NEXT/LOAD/DONE while the baud counter keeps running, so chars are back to back.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_baud   <= '0;
      r_bit    <= '0;
      r_chr    <= '0;
      r_sh     <= '1;
      r_serial <= 1'b1;
      r_cpend  <= 1'b0;
      r_pronto <= 1'b0;
      r_desc   <= 1'b0;
      r_acert  <= 1'b0;
      r_resp   <= '0;
    end else begin
      r_cpend  <= (r_st != S_IDLE) && (r_cpend || cancela);
      r_desc   <= (r_st != S_IDLE) && registrar;
      r_pronto <= (r_st == S_DONE) && w_tick && !w_cancel;
      if (r_st == S_CAPTURE) r_resp <= w_frame;
      if (r_st == S_COMPARE) r_acert <= r_resp == esperado;
      if (w_fire) begin
        if (!w_cancel) begin
          r_serial <= 1'b0;
          r_sh     <= {1'b1, ^w_char, w_char};
          r_baud   <= '0;
          r_bit    <= '0;
          r_chr    <= r_chr + 3'd1;
        end
      end else if (w_run) begin
        r_baud <= w_tick ? '0 : r_baud + 1'b1;
        if (w_tick && r_st == S_SEND) begin
          r_serial <= r_sh[0];
          r_sh     <= {1'b1, r_sh[8:1]};
          r_bit    <= r_bit + 4'd1;
        end
      end
      if (w_nxt == S_IDLE) r_chr <= '0;
    end
  assign serial     = r_serial;
  assign ocupado    = r_st != S_IDLE;
  assign pronto     = r_pronto;
  assign descartada = r_desc;
  assign acertou    = r_acert;
  assign resposta   = r_resp;
endmodule
